// File: rtl/keccak_squeeze_if.sv
// AXI-Stream output bundle of the Keccak squeeze streamer.
// The streamer drives through the master modport; the host output port uses slave.
interface keccak_squeeze_if #(
    parameter int DWIDTH     = 256,
    parameter int KEEP_WIDTH = DWIDTH / 8
);
    logic [DWIDTH-1:0]     tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/keccak_squeeze_streamer.sv
// Squeeze end of the Keccak engine: captures the rate part of each permuted state and streams it as AXI-Stream beats.
// Define KECCAK_SQUEEZE_STATS_EN to add the per-job blocks_squeezed_o counter.
module keccak_squeeze_streamer #(
    parameter int DWIDTH        = 256,
    parameter int KEEP_WIDTH    = DWIDTH / 8,
    parameter int STATE_WIDTH   = 1600,
    parameter int OUT_LEN_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [1:0]               mode_i,
    input  logic [OUT_LEN_WIDTH-1:0] out_len_i,
    input  logic [STATE_WIDTH-1:0]   state_i,
    input  logic                     state_valid_i,
    output logic                     perm_req_o,
    output logic                     busy_o,
    output logic                     done_o,
    keccak_squeeze_if.master         m_axis
`ifdef KECCAK_SQUEEZE_STATS_EN
    ,
    output logic [15:0]              blocks_squeezed_o
`endif
);
    localparam int RATE_WIDTH     = 11;
    localparam int MAX_RATE_BYTES = 168;
    localparam int NUM_WORDS      = (MAX_RATE_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
    localparam int BUF_WIDTH      = NUM_WORDS * DWIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_STATE,
        STREAM,
        REQ_PERM
    } state_e;

    typedef enum logic [1:0] {
        SHA3_256 = 2'd0,
        SHA3_512 = 2'd1,
        SHAKE128 = 2'd2,
        SHAKE256 = 2'd3
    } keccak_mode_e;

    function automatic logic [RATE_WIDTH-1:0] rate_bytes(input logic [1:0] mode);
        case (keccak_mode_e'(mode))
            SHA3_256: rate_bytes = RATE_WIDTH'(136);
            SHA3_512: rate_bytes = RATE_WIDTH'(72);
            SHAKE128: rate_bytes = RATE_WIDTH'(168);
            default:  rate_bytes = RATE_WIDTH'(136);
        endcase
    endfunction

    function automatic logic [OUT_LEN_WIDTH-1:0] job_length(input logic [1:0]               mode,
                                                            input logic [OUT_LEN_WIDTH-1:0] xof_len);
        case (keccak_mode_e'(mode))
            SHA3_256: job_length = OUT_LEN_WIDTH'(32);
            SHA3_512: job_length = OUT_LEN_WIDTH'(64);
            default:  job_length = xof_len;
        endcase
    endfunction

    state_e                              state_q, state_d;
    logic [RATE_WIDTH-1:0]               rate_q, rate_d;
    logic [RATE_WIDTH-1:0]               offset_q, offset_d;
    logic [OUT_LEN_WIDTH-1:0]            remaining_q, remaining_d;
    logic [NUM_WORDS-1:0][DWIDTH-1:0]    buf_q, buf_d;
    logic                                done_q, done_d;

    logic [NUM_WORDS-1:0][DWIDTH-1:0]    capture;
    logic [RATE_WIDTH-1:0]               avail;
    logic [OUT_LEN_WIDTH-1:0]            beat_n;
    logic                                beat_last;
    logic [DWIDTH-1:0]                   window;
    logic [KEEP_WIDTH-1:0]               beat_keep;
    logic [DWIDTH-1:0]                   beat_data;
    logic                                in_stream;
    logic                                accept;

    // State bytes beyond the largest rate never reach the output.
    logic unused_state_hi;
    assign unused_state_hi = ^state_i[STATE_WIDTH-1:BUF_WIDTH];

    // NOTE: every always_comb output gets a default on its first line, so no path can infer a latch.
    always_comb begin
        capture = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            for (int b = 0; b < KEEP_WIDTH; b++) begin
                if ((w * KEEP_WIDTH + b) < int'(rate_q)) begin
                    capture[w][8*b +: 8] = state_i[8*(w*KEEP_WIDTH + b) +: 8];
                end
            end
        end
    end

    // Beat size is min(beat width, bytes left in block, bytes left in job);
    // offsets therefore stay word-aligned and the window is a plain word select.
    always_comb begin
        avail  = rate_q - offset_q;
        beat_n = OUT_LEN_WIDTH'(KEEP_WIDTH);
        if (OUT_LEN_WIDTH'(avail) < beat_n) begin
            beat_n = OUT_LEN_WIDTH'(avail);
        end
        if (remaining_q < beat_n) begin
            beat_n = remaining_q;
        end
        beat_last = (beat_n == remaining_q);

        window = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (offset_q == RATE_WIDTH'(w * KEEP_WIDTH)) begin
                window = buf_q[w];
            end
        end

        beat_keep = '0;
        beat_data = '0;
        for (int b = 0; b < KEEP_WIDTH; b++) begin
            beat_keep[b] = (OUT_LEN_WIDTH'(b) < beat_n);
            if (beat_keep[b]) begin
                beat_data[8*b +: 8] = window[8*b +: 8];
            end
        end
    end

    assign in_stream = (state_q == STREAM);
    assign accept    = in_stream && m_axis.tready;

    always_comb begin
        state_d     = state_q;
        rate_d      = rate_q;
        offset_d    = offset_q;
        remaining_d = remaining_q;
        buf_d       = buf_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    rate_d      = rate_bytes(mode_i);
                    remaining_d = job_length(mode_i, out_len_i);
                    offset_d    = '0;
                    if (job_length(mode_i, out_len_i) == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = WAIT_STATE;
                    end
                end
            end
            WAIT_STATE: begin
                if (state_valid_i) begin
                    buf_d    = capture;
                    offset_d = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    offset_d    = offset_q + RATE_WIDTH'(beat_n);
                    remaining_d = remaining_q - beat_n;
                    if (beat_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (offset_q + RATE_WIDTH'(beat_n) == rate_q) begin
                        state_d = REQ_PERM;
                    end
                end
            end
            REQ_PERM: begin
                state_d = WAIT_STATE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the rate buffer is reset along with the control state so a reset clears every output byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rate_q      <= '0;
            offset_q    <= '0;
            remaining_q <= '0;
            buf_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            offset_q    <= offset_d;
            remaining_q <= remaining_d;
            buf_q       <= buf_d;
            done_q      <= done_d;
        end
    end

    assign m_axis.tvalid = in_stream;
    assign m_axis.tdata  = in_stream ? beat_data : '0;
    assign m_axis.tkeep  = in_stream ? beat_keep : '0;
    assign m_axis.tlast  = in_stream && beat_last;
    assign perm_req_o    = (state_q == REQ_PERM);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;

`ifdef KECCAK_SQUEEZE_STATS_EN
    logic [15:0] blocks_q, blocks_d;

    always_comb begin
        blocks_d = blocks_q;
        if (state_q == IDLE && start_i) begin
            blocks_d = '0;
        end else if (state_q == WAIT_STATE && state_valid_i && blocks_q != 16'hFFFF) begin
            blocks_d = blocks_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocks_q <= '0;
        end else begin
            blocks_q <= blocks_d;
        end
    end

    assign blocks_squeezed_o = blocks_q;
`endif

endmodule

// File: tb/tb_keccak_squeeze_streamer.sv
// Self-checking bench for keccak_squeeze_streamer: directed jobs plus randomized jobs checked
// against a byte-stream reference model built from the rate/length/beat-splitting rules.
module tb_keccak_squeeze_streamer;
  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int SW = 1600;
  localparam int LW = 16;
  localparam int MAX_BLK = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [1:0]    mode_i;
  logic [LW-1:0] out_len_i;
  logic [SW-1:0] state_i;
  logic          state_valid_i;
  logic          perm_req_o;
  logic          busy_o;
  logic          done_o;
`ifdef KECCAK_SQUEEZE_STATS_EN
  logic [15:0]   blocks_squeezed_o;
`endif

  keccak_squeeze_if #(.DWIDTH(DW)) m_axis ();

  keccak_squeeze_streamer #(
    .DWIDTH(DW), .KEEP_WIDTH(KW), .STATE_WIDTH(SW), .OUT_LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .out_len_i(out_len_i),
    .state_i(state_i), .state_valid_i(state_valid_i), .perm_req_o(perm_req_o),
    .busy_o(busy_o), .done_o(done_o), .m_axis(m_axis)
`ifdef KECCAK_SQUEEZE_STATS_EN
    , .blocks_squeezed_o(blocks_squeezed_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          blk_end;
  } beat_t;

  int            checks = 0;
  int            errors = 0;
  beat_t         exp_q[$];
  logic [SW-1:0] blocks[MAX_BLK];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rate_of(input logic [1:0] m);
    case (m)
      2'd0:    return 136;
      2'd1:    return 72;
      2'd2:    return 168;
      default: return 136;
    endcase
  endfunction

  function automatic int len_of(input logic [1:0] m, input int xof_len);
    case (m)
      2'd0:    return 32;
      2'd1:    return 64;
      default: return xof_len;
    endcase
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tvalid"}, m_axis.tvalid, 1'b0);
    check({tag, "_tdata"}, m_axis.tdata, '0);
    check({tag, "_tkeep"}, m_axis.tkeep, '0);
    check({tag, "_tlast"}, m_axis.tlast, 1'b0);
    check({tag, "_perm_req"}, perm_req_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
`ifdef KECCAK_SQUEEZE_STATS_EN
    check({tag, "_blocks"}, blocks_squeezed_o, '0);
`endif
  endtask

  // ready_mode: 0 always ready, 1 random, 2 hold beat 1 for three cycles.
  // abort_beat >= 0 asserts reset while that (0-based) beat is presented.
  task automatic run_job(input logic [1:0] mode, input int out_len, input int ready_mode,
                         input bit count_pat, input int abort_beat, input bit noise);
    int rate, len, nblk, blk_idx, accepted, perm_cnt, hold_cnt, st_delay, pos;
    bit need_state, finished, hold_prev, exp_valid_next, exp_done_next, ready;
    beat_t cur, prev;
    logic [DW-1:0] s_data;
    logic [KW-1:0] s_keep;
    logic s_valid, s_last, s_perm, s_done, s_busy;

    rate = rate_of(mode);
    len  = len_of(mode, out_len);
    nblk = (len + rate - 1) / rate;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < SW / 8; k++) begin
        blocks[b][8*k +: 8] = count_pat ? 8'(k) : 8'($urandom);
      end
    end

    // Output stream = first `rate` bytes of each block, cut at block ends and at 32 bytes.
    exp_q.delete();
    pos = 0;
    while (pos < len) begin
      int off, n;
      off = pos % rate;
      n = rate - off;
      if (n > KW) n = KW;
      if (len - pos < n) n = len - pos;
      cur = '0;
      for (int j = 0; j < n; j++) begin
        cur.data[8*j +: 8] = blocks[pos / rate][8*(off + j) +: 8];
        cur.keep[j] = 1'b1;
      end
      cur.last = (pos + n == len);
      cur.blk_end = (off + n == rate);
      exp_q.push_back(cur);
      pos += n;
    end

    @(posedge clk); #1;
    start_i = 1'b1; mode_i = mode; out_len_i = LW'(out_len);
    @(posedge clk); #1;
    start_i = 1'b0; mode_i = 2'($urandom); out_len_i = LW'($urandom);

    if (len == 0) begin
      check("zero_len_done", done_o, 1'b1);
      check("zero_len_busy", busy_o, 1'b0);
      check("zero_len_tvalid", m_axis.tvalid, 1'b0);
      @(posedge clk); #1;
      check("zero_len_done_width", done_o, 1'b0);
      check("zero_len_no_beat", m_axis.tvalid, 1'b0);
`ifdef KECCAK_SQUEEZE_STATS_EN
      check("zero_len_blocks", blocks_squeezed_o, '0);
`endif
      return;
    end

    check("start_busy", busy_o, 1'b1);
    blk_idx = 0; accepted = 0; perm_cnt = 0; hold_cnt = 0;
    need_state = 1'b1; finished = 1'b0; hold_prev = 1'b0;
    exp_valid_next = 1'b0; exp_done_next = 1'b0;
    st_delay = noise ? $urandom_range(0, 3) : 0;

    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (cyc != 0) begin @(posedge clk); #1; end
      s_data = m_axis.tdata; s_keep = m_axis.tkeep; s_valid = m_axis.tvalid;
      s_last = m_axis.tlast; s_perm = perm_req_o; s_done = done_o; s_busy = busy_o;

      if (exp_valid_next) check("tvalid_next_cycle", s_valid, 1'b1);
      if (hold_prev) begin
        check("hold_tvalid", s_valid, 1'b1);
        check("hold_tdata", s_data, prev.data);
        check("hold_tkeep", s_keep, prev.keep);
        check("hold_tlast", s_last, prev.last);
      end
      exp_valid_next = 1'b0;

      if (exp_done_next) begin
        check("done_pulse", s_done, 1'b1);
        check("busy_after_done", s_busy, 1'b0);
        check("tvalid_after_done", s_valid, 1'b0);
        finished = 1'b1;
      end else begin
        if (abort_beat >= 0 && accepted == abort_beat && s_valid) begin
          rst = 1'b1;
          #1;
          check_outputs_zero("abort_reset");
          @(posedge clk); #1;
          rst = 1'b0; state_valid_i = 1'b0; start_i = 1'b0;
          exp_q.delete();
          return;
        end
        if (s_perm) begin
          perm_cnt++;
          need_state = 1'b1;
          st_delay = noise ? $urandom_range(1, 3) : 1;
        end

        case (ready_mode)
          0: ready = 1'b1;
          1: ready = ($urandom_range(0, 3) != 0);
          default: begin
            if (s_valid && accepted == 0 && hold_cnt < 3) begin
              ready = 1'b0;
              hold_cnt++;
            end else begin
              ready = 1'b1;
            end
          end
        endcase
        m_axis.tready = ready;

        state_valid_i = 1'b0;
        if (need_state) begin
          if (st_delay == 0) begin
            state_i = (blk_idx < nblk) ? blocks[blk_idx] : '1;
            blk_idx++;
            state_valid_i = 1'b1;
            need_state = 1'b0;
            exp_valid_next = 1'b1;
          end else begin
            st_delay--;
          end
        end else if (noise && $urandom_range(0, 7) == 0) begin
          state_i = {50{$urandom}};
          state_valid_i = 1'b1;
        end

        if (noise && s_busy && !(s_valid && ready && s_last) && $urandom_range(0, 5) == 0) begin
          start_i = 1'b1; mode_i = 2'($urandom); out_len_i = LW'($urandom);
        end else begin
          start_i = 1'b0;
        end

        #1;
        if (s_valid && ready) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", s_valid, 1'b0);
          end else begin
            cur = exp_q.pop_front();
            check("beat_tdata", s_data, cur.data);
            check("beat_tkeep", s_keep, cur.keep);
            check("beat_tlast", s_last, cur.last);
            accepted++;
            if (cur.last) exp_done_next = 1'b1;
            else if (!cur.blk_end) exp_valid_next = 1'b1;
          end
        end
        hold_prev = s_valid && !ready;
        prev.data = s_data; prev.keep = s_keep; prev.last = s_last; prev.blk_end = 1'b0;
      end
    end

    start_i = 1'b0; state_valid_i = 1'b0;
    if (!finished) check("job_timeout", finished, 1'b1);
    check("perm_req_count", perm_cnt, nblk - 1);
    check("beats_left", exp_q.size(), 0);
`ifdef KECCAK_SQUEEZE_STATS_EN
    check("blocks_squeezed", blocks_squeezed_o, nblk);
`endif
    @(posedge clk); #1;
    check("done_width", done_o, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; mode_i = 2'd0; out_len_i = '0;
    state_i = '0; state_valid_i = 1'b0; m_axis.tready = 1'b0;
    #12;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_job(2'd0, 0, 0, 1'b1, -1, 1'b0);    // SHA3_256 single full beat
    run_job(2'd1, 0, 0, 1'b1, -1, 1'b0);    // SHA3_512 two beats
    run_job(2'd2, 200, 0, 1'b1, -1, 1'b0);  // SHAKE128 across a block boundary
    run_job(2'd3, 5, 0, 1'b1, -1, 1'b0);    // SHAKE256 short partial beat
    run_job(2'd3, 0, 0, 1'b0, -1, 1'b0);    // zero-length job
    run_job(2'd1, 0, 2, 1'b1, -1, 1'b0);    // back-pressure on beat 1
    run_job(2'd2, 200, 0, 1'b1, 2, 1'b0);   // reset during beat 3
    run_job(2'd0, 0, 0, 1'b1, -1, 1'b0);    // clean job after reset

    for (int i = 0; i < 24; i++) begin
      logic [1:0] m;
      int ol;
      m = 2'($urandom);
      ol = $urandom_range(0, 900);
      if ($urandom_range(0, 5) == 0) ol = $urandom_range(0, 3);
      run_job(m, ol, 1, 1'b0, -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keccak_squeeze_streamer.md
Name: keccak_squeeze_streamer

Overview:
- Output (squeeze) end of the Keccak engine, the counterpart of the 256-bit keep-qualified absorb input.
- After each permutation, captures the rate portion of the 1600-bit state and streams digest/XOF bytes as 256-bit AXI-Stream beats.
- Requests further permutations for SHAKE outputs longer than one rate block.
- Sits between the permutation core and the host output port.

Parameters:
- DWIDTH, 256, output beat width in bits (32 bytes).
- KEEP_WIDTH, DWIDTH/8, one tkeep bit per byte.
- STATE_WIDTH, 1600, flattened state width (25 lanes x 64).
- OUT_LEN_WIDTH, 16, width of requested XOF length in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start_i  in  1  begin squeeze job; sampled only in IDLE
- mode_i  in  2  keccak_mode: SHA3_256=0, SHA3_512=1, SHAKE128=2, SHAKE256=3
- out_len_i  in  OUT_LEN_WIDTH  SHAKE output byte count; ignored for SHA3 modes
- state_i  in  STATE_WIDTH  permuted state; byte k at bits [8k+7:8k], lane (x,y) at index x+5y
- state_valid_i  in  1  single-cycle pulse: state_i holds a completed permutation
- perm_req_o  out  1  single-cycle pulse: permute again for more output
- m_axis_tdata  out  DWIDTH  output bytes, byte 0 in bits [7:0]
- m_axis_tkeep  out  KEEP_WIDTH  valid bytes, always contiguous from bit 0
- m_axis_tvalid  out  1  beat valid
- m_axis_tlast  out  1  final beat of job
- m_axis_tready  in  1  downstream accept
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  single-cycle pulse when job completes

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; rate buffer, offset and remaining counters cleared. Mid-job reset aborts immediately with no tlast or done.
- Rate in bytes (RATE_WIDTH=11 bits): SHA3_256=136, SHA3_512=72, SHAKE128=168, SHAKE256=136. Fixed length: SHA3_256=32, SHA3_512=64, SHAKE = out_len_i.
- FSM states: IDLE, WAIT_STATE, STREAM, REQ_PERM.
- IDLE, start_i=1: latch mode, rate, remaining=length.
  - remaining==0 -> done_o pulse next cycle, stay IDLE, no beats.
  - otherwise -> WAIT_STATE.
  - start_i while busy is ignored.
- WAIT_STATE, state_valid_i=1: register the low rate bytes of state_i into the buffer; offset=0; -> STREAM. m_axis_tvalid rises the cycle after the pulse.
- state_valid_i outside WAIT_STATE is ignored.
- STREAM:
  - Beat byte count n = min(32, rate - offset, remaining). Beats never straddle blocks, so the block-tail beat is partial.
  - tdata = buffer bytes [offset .. offset+n-1] in lanes 0..n-1; unused lanes are 0; tkeep = (1<<n)-1.
  - tlast = (n == remaining).
  - On tvalid && tready: offset += n; remaining -= n.
  - If tlast beat: -> IDLE, done_o pulse the same edge.
  - Else if offset reaches rate: -> REQ_PERM.
  - Else present the next beat the following cycle, allowing one beat per cycle under constant tready.
- AXI rule: tdata, tkeep and tlast are held stable while tvalid=1 and tready=0. tvalid never drops without acceptance.
- REQ_PERM: perm_req_o=1 for exactly one cycle; -> WAIT_STATE.
- Arithmetic: remaining is OUT_LEN_WIDTH bits and never underflows (n <= remaining). offset never exceeds rate.

Optional Feature:
- Macro: KECCAK_SQUEEZE_STATS_EN.
- Defined:
  - Adds output port blocks_squeezed_o (16 bits): count of state blocks captured in the current job.
  - Cleared when start_i is accepted; incremented on each state_valid_i accepted in WAIT_STATE.
  - Holds its value after done; reset value 0; saturates at 16'hFFFF.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
1. SHA3_256; state bytes k = k mod 256; state_valid_i at cycle 5; tready=1 -> one beat at cycle 6, tdata bytes 0x00..0x1F, tkeep=32'hFFFFFFFF, tlast=1; done_o pulse; perm_req_o never asserted.
2. SHA3_512, same state -> two beats (bytes 0x00-0x1F, then 0x20-0x3F), both full tkeep, tlast on beat 2; no perm_req_o.
3. SHAKE128, out_len_i=200 -> beats of 32,32,32,32,32 bytes, then 8 bytes (tkeep=32'hFF, tlast=0), then a perm_req_o pulse. Second state_valid_i -> one 32-byte beat with tlast=1. With macro defined, blocks_squeezed_o=2.
4. SHAKE256, out_len_i=5 -> single beat, tkeep=32'h1F, bytes 5..31 zero, tlast=1. Also out_len_i=0 -> done_o with no beats.
5. SHA3_512 with tready held low 3 cycles on beat 1 -> tdata/tkeep/tlast stable, tvalid held; beat 2 follows acceptance by one cycle.
6. Assert rst during beat 3 of the test 3 job -> all outputs 0 asynchronously, busy_o=0. A new start_i then runs test 1 correctly. Also, start_i pulsed mid-job has no effect.
